// File: rtl/alu_issue.sv
// Operand-issue and writeback stage for the 2-bit-opcode ALU.
// Holds a small register file and runs one command at a time: IDLE -> EXEC -> RESP.
module alu_issue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    localparam int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_W-1:0]     cmd_rd_i,
    input  logic [ADDR_W-1:0]     cmd_rs1_i,
    input  logic [ADDR_W-1:0]     cmd_rs2_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [1:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_c_i,
    input  logic                  alu_carry_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_carry_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]            op_q;
    logic [ADDR_W-1:0]     rd_q;
    logic [ADDR_W-1:0]     rs1_q;
    logic [ADDR_W-1:0]     rs2_q;
    logic [DATA_WIDTH-1:0] rf [NUM_REGS];

    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_carry_q;

    logic accept;
    assign accept = (state_q == IDLE) && cmd_valid_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ALU drive; operands only leave zero during EXEC
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        alu_op_o    = 2'b00;
        alu_a_o     = '0;
        alu_b_o     = '0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_op_o = op_q;
                alu_a_o  = rf[rs1_q];
                alu_b_o  = rf[rs2_q];
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command capture; every field is latched on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= 2'b00;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            op_q  <= cmd_op_i;
            rd_q  <= cmd_rd_i;
            rs1_q <= cmd_rs1_i;
            rs2_q <= cmd_rs2_i;
        end
    end

    // Register file: writeback is ordered last so it wins an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                rf[wr_addr_i] <= wr_data_i;
            end
            if (state_q == EXEC) begin
                rf[rd_q] <= alu_c_i;
            end
        end
    end

    // Response registers, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_c_i;
            rsp_carry_q <= alu_carry_i;
        end else if ((state_q == RESP) && rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_carry_o = rsp_carry_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU on its operand port.
module tb_alu_issue;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_c;
    logic          alu_carry;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_carry;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_rd_i   (cmd_rd),
        .cmd_rs1_i  (cmd_rs1),
        .cmd_rs2_i  (cmd_rs2),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .alu_op_o   (alu_op),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_c_i    (alu_c),
        .alu_carry_i(alu_carry),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_carry_o(rsp_carry)
    );

    // Behavioural ALU: 33-bit sum/difference of sign-extended operands
    always_comb begin
        logic [DW:0] r;
        case (alu_op)
            2'b00:   r = {alu_a[DW-1], alu_a} + {alu_b[DW-1], alu_b};
            2'b01:   r = {alu_a[DW-1], alu_a} - {alu_b[DW-1], alu_b};
            2'b10:   r = {1'b0, alu_a ^ alu_b};
            default: r = {1'b0, alu_a & alu_b};
        endcase
        alu_c     = r[DW-1:0];
        alu_carry = r[DW];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Present a command in IDLE; returns one cycle later in EXEC
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        chk1("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic exec_chk(input string tag, input logic [1:0] op,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        chk({tag, "_op"}, {30'd0, alu_op}, {30'd0, op});
        chk({tag, "_a"}, alu_a, a);
        chk({tag, "_b"}, alu_b, b);
        chk1({tag, "_rdy0"}, cmd_ready, 1'b0);
        chk1({tag, "_vld0"}, rsp_valid, 1'b0);
    endtask

    // Called one edge after EXEC: checks the response then consumes it
    task automatic rsp_chk(input string tag, input logic [DW-1:0] d, input logic c);
        chk1({tag, "_vld"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_data, d);
        chk1({tag, "_carry"}, rsp_carry, c);
        chk({tag, "_a_idle"}, alu_a, '0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk1({tag, "_vld_clr"}, rsp_valid, 1'b0);
        chk1({tag, "_rdy_back"}, cmd_ready, 1'b1);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] d, input logic c);
        issue(op, rd, rs1, rs2);
        exec_chk(tag, op, a, b);
        tick();
        rsp_chk(tag, d, c);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rd    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_carry", rsp_carry, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("rst_ready", cmd_ready, 1'b1);

        // Basic add then xor of a register with itself
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        run("t1_add", 2'b00, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 32'd8, 1'b0);
        run("t1_xor", 2'b10, 3'd4, 3'd3, 3'd3, 32'd8, 32'd8, 32'd0, 1'b0);

        // Carry cases
        load(3'd1, 32'h8000_0000);
        load(3'd2, 32'h8000_0000);
        run("t2_add", 2'b00, 3'd5, 3'd1, 3'd2, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1);
        load(3'd1, 32'd3);
        load(3'd2, 32'd5);
        run("t2_sub", 2'b01, 3'd5, 3'd1, 3'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1);

        // Back-pressure with a second command waiting
        issue(2'b10, 3'd7, 3'd1, 3'd2);
        exec_chk("t3_xor", 2'b10, 32'd3, 32'd5);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_rd    = 3'd0;
        cmd_rs1   = 3'd1;
        cmd_rs2   = 3'd2;
        for (int i = 0; i < 4; i++) begin
            chk1("t3_hold_vld", rsp_valid, 1'b1);
            chk("t3_hold_data", rsp_data, 32'd6);
            chk1("t3_hold_carry", rsp_carry, 1'b0);
            chk1("t3_hold_rdy", cmd_ready, 1'b0);
            chk("t3_hold_a", alu_a, '0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk1("t3_rel_vld", rsp_valid, 1'b0);
        chk1("t3_rel_rdy", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        exec_chk("t3_add", 2'b00, 32'd3, 32'd5);
        tick();
        rsp_chk("t3_add", 32'd8, 1'b0);

        // Dependency chain with rd == rs1 == rs2
        load(3'd1, 32'd1);
        run("t4_a", 2'b00, 3'd1, 3'd1, 3'd1, 32'd1, 32'd1, 32'd2, 1'b0);
        run("t4_b", 2'b00, 3'd1, 3'd1, 3'd1, 32'd2, 32'd2, 32'd4, 1'b0);
        run("t4_rd", 2'b11, 3'd1, 3'd1, 3'd1, 32'd4, 32'd4, 32'd4, 1'b0);

        // Load to rd during EXEC loses to writeback
        load(3'd1, 32'd10);
        load(3'd2, 32'd20);
        issue(2'b00, 3'd6, 3'd1, 3'd2);
        exec_chk("t5_wb", 2'b00, 32'd10, 32'd20);
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 32'hDEAD;
        tick();
        wr_en   = 1'b0;
        rsp_chk("t5_wb", 32'd30, 1'b0);
        run("t5_rd6", 2'b11, 3'd6, 3'd6, 3'd6, 32'd30, 32'd30, 32'd30, 1'b0);

        // Load to rs1 during EXEC is not seen until the next command
        issue(2'b00, 3'd7, 3'd1, 3'd2);
        exec_chk("t5_old", 2'b00, 32'd10, 32'd20);
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 32'hDEAD;
        tick();
        wr_en   = 1'b0;
        rsp_chk("t5_old", 32'd30, 1'b0);
        run("t5_new", 2'b00, 3'd7, 3'd1, 3'd2, 32'hDEAD, 32'd20, 32'hDEC1, 1'b0);

        // Asynchronous reset in EXEC
        issue(2'b00, 3'd3, 3'd1, 3'd2);
        chk("t6_pre_a", alu_a, 32'hDEAD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_op", {30'd0, alu_op}, 32'd0);
        chk("t6_a", alu_a, '0);
        chk("t6_b", alu_b, '0);
        chk1("t6_vld", rsp_valid, 1'b0);
        chk("t6_data", rsp_data, '0);
        chk1("t6_carry", rsp_carry, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        chk1("t6_rdy", cmd_ready, 1'b1);
        for (int i = 0; i < NR; i++) begin
            run("t6_rf0", 2'b11, 3'(i), 3'(i), 3'(i), 32'd0, 32'd0, 32'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Operand-issue and writeback stage that sits directly upstream of the 2-bit-opcode ALU. It holds a small register file and accepts ALU commands (op, rd, rs1, rs2) over a valid/ready handshake. For each command it drives the ALU operand/opcode inputs, captures the combinational ALU result and carry, writes the result back to rd, and returns it on a response handshake.

Parameters:
DATA_WIDTH, 32, operand/result width; must match the ALU.
NUM_REGS, 8, register-file depth; power of two, at least 2.
ADDR_W, $clog2(NUM_REGS), register index width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  00 add, 01 sub, 10 xor, 11 and
cmd_rd_i  in  ADDR_W  destination register
cmd_rs1_i  in  ADDR_W  source A register
cmd_rs2_i  in  ADDR_W  source B register
wr_en_i  in  1  external register load strobe
wr_addr_i  in  ADDR_W  external load address
wr_data_i  in  DATA_WIDTH  external load data
alu_op_o  out  2  to ALU op_i
alu_a_o  out  DATA_WIDTH  to ALU data_a_i
alu_b_o  out  DATA_WIDTH  to ALU data_b_i
alu_c_i  in  DATA_WIDTH  from ALU data_c_o
alu_carry_i  in  1  from ALU c_o
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  DATA_WIDTH  result written to rd
rsp_carry_o  out  1  carry of that result

Behaviour:
- Single clock; asynchronous active-low reset on rst_n. All flops clear immediately on rst_n=0.
- Reset values:
  - FSM=IDLE; all register-file entries 0.
  - cmd_ready_o=1 after reset release.
  - alu_op_o=0, alu_a_o=0, alu_b_o=0.
  - rsp_valid_o=0, rsp_data_o=0, rsp_carry_o=0.
- FSM has 3 states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch op/rd/rs1/rs2 into command registers, go to EXEC.
- EXEC (exactly 1 cycle):
  - cmd_ready_o=0.
  - alu_op_o = latched op; alu_a_o = rf[rs1]; alu_b_o = rf[rs2], read combinationally from current contents.
  - At the closing edge: rf[rd] <= alu_c_i; rsp_data_o <= alu_c_i; rsp_carry_o <= alu_carry_i; rsp_valid_o <= 1; go to RESP.
- RESP:
  - cmd_ready_o=0.
  - Response outputs held stable while rsp_ready_i=0.
  - On rsp_ready_i: rsp_valid_o <= 0, go to IDLE.
- Outside EXEC, alu_op_o/alu_a_o/alu_b_o are driven to 0.
- Latency and throughput:
  - Command accept edge to rsp_valid_o high: 2 edges.
  - Minimum 3 cycles per command; no overlap of commands.
- Carry is passed through unmodified. For xor/and the ALU supplies 0.
- External load:
  - wr_en_i writes rf[wr_addr_i] on any cycle, in any state.
  - Same address as EXEC writeback in the same cycle: writeback wins.
  - Different addresses: both writes complete.
  - A load during EXEC to rs1/rs2 is not seen by the current command; the operand uses the pre-edge value.
- rd may equal rs1 and/or rs2; the old value is read, the new value is written.
- Reset mid-operation, in any state: command dropped, rf cleared, FSM to IDLE, outputs to reset values.
- No X propagation: unused command fields are still latched in IDLE, but are don't-care.

Test Plan:
Bench connects a behavioural ALU model: {carry,c} = 33-bit sum/diff of sign-extended operands; xor/and give carry=0.
1. Load r1=5, r2=3; cmd add rd=3 -> EXEC shows alu_a_o=5, alu_b_o=3, alu_op_o=00; rsp_data_o=8, rsp_carry_o=0 exactly 2 edges after accept; a later cmd xor rd=4 rs1=3 rs2=3 returns 0.
2. r1=0x80000000, r2=0x80000000, add rd=5 -> rsp_data_o=0, rsp_carry_o=1; r1=3, r2=5, sub -> rsp_data_o=0xFFFFFFFE, rsp_carry_o=1.
3. Back-pressure: hold rsp_ready_i=0 for 4 cycles with cmd_valid_i=1 -> rsp_* stable, cmd_ready_o=0, second command not accepted until the cycle after rsp_ready_i=1.
4. Dependency chain: r1=1; add rd=1 rs1=1 rs2=1 twice -> responses 2 then 4; r1 reads back 4.
5. Same-cycle collision: wr_en_i to rd during EXEC with 0xDEAD -> rf[rd] holds the ALU result. Load to rs1 during EXEC -> operand uses the old value, the next command sees 0xDEAD.
6. Assert rst_n=0 during EXEC -> all outputs 0 asynchronously (before the next clock edge); after release cmd_ready_o=1 and all registers read 0.
